// File: rtl/frequency_pattern_generator_pkg.sv
// -----------------------------------------------------------------------------
// frequency_pattern_generator_pkg
// Shared definitions for the frequency pattern generator:
//   - FSM state encodings (IDLE / RUN / STOP)
//   - pixel index type (10-bit, wrapping)
//   - half_period(): clock cycles per half period of a square wave at a given
//     frequency, usable in constant expressions by both the generator and
//     analyzer benches.
// -----------------------------------------------------------------------------
package frequency_pattern_generator_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_STOP = 2'd2;

  localparam int INDEX_WIDTH = 10;
  typedef logic [INDEX_WIDTH-1:0] index_t;

  // Integer division is done in 64 bits so that 2*frequency cannot overflow;
  // a result of zero (frequency above half the clock rate) is clamped to 1,
  // and a zero frequency yields the longest representable half period.
  function automatic logic [31:0] half_period(input int unsigned clock_frequency,
                                              input int unsigned frequency);
    longint unsigned h;
    if (frequency == 0) begin
      h = 64'h0000_0000_FFFF_FFFF;
    end else begin
      h = longint'(clock_frequency) / (64'd2 * longint'(frequency));
      if (h == 0) h = 1;
    end
    return h[31:0];
  endfunction

endpackage

// File: rtl/frequency_pattern_generator_square_wave_source.sv
// -----------------------------------------------------------------------------
// square_wave_source
// One blinking-pixel square wave with two selectable half periods.
// Ports:
//   clock    sole clock
//   aresetn  asynchronous active-low reset (counter and phase cleared)
//   clear    synchronous restart: counter to 0, phase low
//   enable   advance the wave this cycle (frozen otherwise)
//   select   1 = HALF1, 0 = HALF0
//   wave     current phase
// -----------------------------------------------------------------------------
module square_wave_source #(
  parameter logic [31:0] HALF0 = 32'd1,
  parameter logic [31:0] HALF1 = 32'd1
) (
  input  logic clock,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  input  logic select,
  output logic wave
);

  logic [31:0] half;
  logic [31:0] count;

  assign half = select ? HALF1 : HALF0;

  // Phase toggles on the cycle the counter reaches half-1, so each level lasts
  // exactly 'half' enabled cycles. Half periods are at least 1 by construction.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
      wave  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      wave  <= 1'b0;
    end else if (enable) begin
      if (count >= half - 32'd1) begin
        count <= '0;
        wave  <= ~wave;
      end else begin
        count <= count + 32'd1;
      end
    end
  end

endmodule

// File: rtl/frequency_pattern_generator.sv
// -----------------------------------------------------------------------------
// frequency_pattern_generator
// Emits a burst of synthetic line-scan pixels in which three positions blink at
// selectable frequencies, and drives start/stop handshakes for an analyzer.
// Ports:
//   clock        sole clock
//   aresetn      asynchronous active-low reset
//   trigger      one-cycle burst request (accepted only in IDLE)
//   freq_select  per-pixel frequency choice, latched with the trigger
//   done_ack     analyzer write-back confirmation, ends STOP
//   data         8-bit pixel value
//   pixel_clock  pixel strobe, rising edge centred on stable data
//   start        one-cycle pulse on the first RUN cycle
//   stop         high from burst end until acknowledged
//   busy         high whenever not IDLE
// -----------------------------------------------------------------------------
module frequency_pattern_generator
  import frequency_pattern_generator_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY   = 100000000,
  parameter int unsigned LINE_LENGTH       = 1024,
  parameter int unsigned PIXEL_DIVIDER     = 4,
  parameter int unsigned PIXEL0_INDEX      = 63,
  parameter int unsigned PIXEL1_INDEX      = 511,
  parameter int unsigned PIXEL2_INDEX      = 1023,
  parameter int unsigned PIXEL0_FREQUENCY0 = 5000,
  parameter int unsigned PIXEL0_FREQUENCY1 = 10000,
  parameter int unsigned PIXEL1_FREQUENCY0 = 15000,
  parameter int unsigned PIXEL1_FREQUENCY1 = 20000,
  parameter int unsigned PIXEL2_FREQUENCY0 = 25000,
  parameter int unsigned PIXEL2_FREQUENCY1 = 30000,
  parameter int unsigned RUN_CYCLES        = 100000000,
  parameter logic [7:0]  BACKGROUND        = 8'h00,
  parameter logic [7:0]  FOREGROUND        = 8'hFF
) (
  input  logic       clock,
  input  logic       aresetn,
  input  logic       trigger,
  input  logic [2:0] freq_select,
  input  logic       done_ack,
  output logic [7:0] data,
  output logic       pixel_clock,
  output logic       start,
  output logic       stop,
  output logic       busy
);

  localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES - 1);
  localparam logic [31:0] DIV_LAST  = 32'(PIXEL_DIVIDER - 1);
  localparam logic [31:0] DIV_HALF  = 32'(PIXEL_DIVIDER / 2);
  localparam index_t      LINE_LAST = index_t'(LINE_LENGTH - 1);
  localparam index_t      P0        = index_t'(PIXEL0_INDEX);
  localparam index_t      P1        = index_t'(PIXEL1_INDEX);
  localparam index_t      P2        = index_t'(PIXEL2_INDEX);

  logic [1:0]  state;
  logic [31:0] run_count;
  logic [31:0] div_count;
  logic [31:0] div_next;
  index_t      pixel_index;
  index_t      index_next;
  logic [2:0]  select_latch;
  logic [2:0]  wave;
  logic        lit;
  logic        wave_clear;
  logic        wave_enable;

  assign wave_clear  = (state == STATE_IDLE) && trigger;
  assign wave_enable = (state == STATE_RUN);

  square_wave_source #(
    .HALF0(half_period(CLOCK_FREQUENCY, PIXEL0_FREQUENCY0)),
    .HALF1(half_period(CLOCK_FREQUENCY, PIXEL0_FREQUENCY1))
  ) wave0 (
    .clock(clock), .aresetn(aresetn), .clear(wave_clear),
    .enable(wave_enable), .select(select_latch[0]), .wave(wave[0])
  );

  square_wave_source #(
    .HALF0(half_period(CLOCK_FREQUENCY, PIXEL1_FREQUENCY0)),
    .HALF1(half_period(CLOCK_FREQUENCY, PIXEL1_FREQUENCY1))
  ) wave1 (
    .clock(clock), .aresetn(aresetn), .clear(wave_clear),
    .enable(wave_enable), .select(select_latch[1]), .wave(wave[1])
  );

  square_wave_source #(
    .HALF0(half_period(CLOCK_FREQUENCY, PIXEL2_FREQUENCY0)),
    .HALF1(half_period(CLOCK_FREQUENCY, PIXEL2_FREQUENCY1))
  ) wave2 (
    .clock(clock), .aresetn(aresetn), .clear(wave_clear),
    .enable(wave_enable), .select(select_latch[2]), .wave(wave[2])
  );

  // Next divider count and next pixel index; the lit decision looks at the
  // index being loaded so data and index change together. Lower-numbered
  // pixels take priority when positions coincide.
  always_comb begin
    div_next   = (div_count == DIV_LAST) ? '0 : div_count + 32'd1;
    index_next = (pixel_index == LINE_LAST) ? '0 : pixel_index + index_t'(1);
    lit        = 1'b0;
    if (index_next == P0) begin
      lit = wave[0];
    end else if (index_next == P1) begin
      lit = wave[1];
    end else if (index_next == P2) begin
      lit = wave[2];
    end
  end

  // Control FSM and pixel stream. The pixel counters advance on every RUN
  // edge, including the one that enters STOP, and then hold through STOP and
  // IDLE. A trigger loads index 0 with all phases low, so the first pixel is
  // always BACKGROUND.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state        <= STATE_IDLE;
      run_count    <= '0;
      div_count    <= '0;
      pixel_index  <= '0;
      select_latch <= '0;
      data         <= BACKGROUND;
      pixel_clock  <= 1'b0;
      start        <= 1'b0;
      stop         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (trigger) begin
            state        <= STATE_RUN;
            select_latch <= freq_select;
            run_count    <= '0;
            div_count    <= '0;
            pixel_index  <= '0;
            data         <= BACKGROUND;
            pixel_clock  <= 1'b0;
            start        <= 1'b1;
            busy         <= 1'b1;
          end
        end
        STATE_RUN: begin
          run_count   <= run_count + 32'd1;
          div_count   <= div_next;
          pixel_clock <= (div_next >= DIV_HALF);
          if (div_next == '0) begin
            pixel_index <= index_next;
            data        <= lit ? FOREGROUND : BACKGROUND;
          end
          if (run_count == RUN_LAST) begin
            state <= STATE_STOP;
            stop  <= 1'b1;
          end
        end
        STATE_STOP: begin
          if (done_ack) begin
            state <= STATE_IDLE;
            stop  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= STATE_IDLE;
          stop  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_frequency_pattern_generator
// Self-checking bench: a cycle-level model computes every output from the
// number of cycles elapsed since the burst began, and a compare process checks
// all DUT outputs against it on every falling clock edge. Directed literal
// checks pin latency, handshake and reset behaviour.
// -----------------------------------------------------------------------------
module tb_frequency_pattern_generator;

  localparam int unsigned CLK_F = 1000;
  localparam int unsigned PD    = 4;
  localparam int unsigned LL    = 16;
  localparam int unsigned RC    = 200;
  localparam int unsigned P0_IDX = 3;
  localparam int unsigned P1_IDX = 7;
  localparam int unsigned P2_IDX = 12;
  localparam int unsigned P0_F0 = 100;
  localparam int unsigned P0_F1 = 50;
  localparam int unsigned P1_F0 = 125;
  localparam int unsigned P1_F1 = 250;
  localparam int unsigned P2_F0 = 40;
  localparam int unsigned P2_F1 = 5000;
  localparam logic [7:0] BG = 8'h00;
  localparam logic [7:0] FG = 8'hFF;

  logic       clock = 1'b0;
  logic       aresetn = 1'b0;
  logic       trigger = 1'b0;
  logic [2:0] freq_select = 3'b000;
  logic       done_ack = 1'b0;
  logic [7:0] data;
  logic       pixel_clock;
  logic       start;
  logic       stop;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  frequency_pattern_generator #(
    .CLOCK_FREQUENCY(CLK_F), .LINE_LENGTH(LL), .PIXEL_DIVIDER(PD),
    .PIXEL0_INDEX(P0_IDX), .PIXEL1_INDEX(P1_IDX), .PIXEL2_INDEX(P2_IDX),
    .PIXEL0_FREQUENCY0(P0_F0), .PIXEL0_FREQUENCY1(P0_F1),
    .PIXEL1_FREQUENCY0(P1_F0), .PIXEL1_FREQUENCY1(P1_F1),
    .PIXEL2_FREQUENCY0(P2_F0), .PIXEL2_FREQUENCY1(P2_F1),
    .RUN_CYCLES(RC), .BACKGROUND(BG), .FOREGROUND(FG)
  ) dut (
    .clock(clock), .aresetn(aresetn), .trigger(trigger),
    .freq_select(freq_select), .done_ack(done_ack), .data(data),
    .pixel_clock(pixel_clock), .start(start), .stop(stop), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference arithmetic: half period per pixel and selection, wave phase at
  // a given cycle since burst entry, and the pixel value shown at that cycle.
  function automatic int half_of(input int unsigned f);
    int unsigned h;
    h = CLK_F / (2 * f);
    return (h == 0) ? 1 : int'(h);
  endfunction

  function automatic int half_for(input int n, input logic [2:0] sel);
    case (n)
      0:       return half_of(sel[0] ? P0_F1 : P0_F0);
      1:       return half_of(sel[1] ? P1_F1 : P1_F0);
      default: return half_of(sel[2] ? P2_F1 : P2_F0);
    endcase
  endfunction

  function automatic bit wave_at(input int n, input logic [2:0] sel, input int k);
    return ((k / half_for(n, sel)) % 2) == 1;
  endfunction

  // Pixel p is loaded at cycle p*PD using the phases of the cycle before.
  function automatic logic [7:0] data_at(input int k, input logic [2:0] sel);
    int p;
    int idx;
    int j;
    p = k / PD;
    if (p == 0) return BG;
    idx = p % LL;
    j = p * PD;
    if (idx == P0_IDX) return wave_at(0, sel, j - 1) ? FG : BG;
    if (idx == P1_IDX) return wave_at(1, sel, j - 1) ? FG : BG;
    if (idx == P2_IDX) return wave_at(2, sel, j - 1) ? FG : BG;
    return BG;
  endfunction

  // Behavioural model: mode plus cycles elapsed since the burst began.
  typedef enum int {M_IDLE, M_RUN, M_STOP} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_k = 0;
  logic [2:0] m_sel = 3'b000;
  bit         m_ran = 1'b0;

  always @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      m_mode = M_IDLE;
      m_k    = 0;
      m_sel  = 3'b000;
      m_ran  = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (trigger) begin
          m_mode = M_RUN;
          m_k    = 0;
          m_sel  = freq_select;
          m_ran  = 1'b1;
        end
        M_RUN: begin
          m_k = m_k + 1;
          if (m_k == RC) m_mode = M_STOP;
        end
        default: if (done_ack) m_mode = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    logic [7:0] e_data;
    logic       e_pclk;
    logic       e_start;
    logic       e_stop;
    logic       e_busy;
    if (checking) begin
      e_data  = m_ran ? data_at(m_k, m_sel) : BG;
      e_pclk  = m_ran ? ((m_k % PD) >= (PD / 2)) : 1'b0;
      e_start = (m_mode == M_RUN) && (m_k == 0);
      e_stop  = (m_mode == M_STOP);
      e_busy  = (m_mode != M_IDLE);
      vectors = vectors + 1;
      if ({data, pixel_clock, start, stop, busy} !== {e_data, e_pclk, e_start, e_stop, e_busy}) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL cycle_model t=%0t: got data=%h pclk=%b start=%b stop=%b busy=%b, expected data=%h pclk=%b start=%b stop=%b busy=%b",
                 $time, data, pixel_clock, start, stop, busy, e_data, e_pclk, e_start, e_stop, e_busy);
      end
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    vectors = vectors + 1;
    if (actual != expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulse_trigger(input logic [2:0] sel);
    freq_select = sel;
    trigger = 1'b1;
    @(posedge clock);
    #1;
    trigger = 1'b0;
  endtask

  // One burst: trigger, optional input noise during RUN, STOP handshake.
  task automatic apply_stimulus(input logic [2:0] sel, input bit noise,
                                input bit ack_tied, input int ack_delay);
    int n;
    int high;
    pulse_trigger(sel);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        check_output("start_pulse", start, 1);
        check_output("busy_rise", busy, 1);
      end
      if (!stop) begin
        #1;
        trigger  = noise ? 1'($urandom_range(0, 1)) : (n == 100);
        done_ack = ack_tied ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end while (!stop && n < int'(RC) + 50);
    check_output("stop_latency", n, RC + 1);
    #1;
    trigger = 1'b0;
    if (ack_tied) begin
      high = 1;
      @(negedge clock);
      while (stop && high < 10) begin
        high++;
        @(negedge clock);
      end
      check_output("early_ack_stop_width", high, 1);
      #1;
      done_ack = 1'b0;
    end else begin
      done_ack = 1'b0;
      for (int i = 0; i < ack_delay; i++) begin
        trigger = noise ? 1'($urandom_range(0, 1)) : (i == 10);
        @(negedge clock);
        #1;
      end
      trigger = 1'b0;
      check_output("stop_held", stop, 1);
      done_ack = 1'b1;
      @(negedge clock);
      check_output("stop_release", stop, 0);
      check_output("busy_release", busy, 0);
      #1;
      done_ack = 1'b0;
    end
  endtask

  initial begin
    aresetn = 1'b0;
    repeat (3) @(negedge clock);
    check_output("reset_data", data, BG);
    check_output("reset_pclk", pixel_clock, 0);
    check_output("reset_start", start, 0);
    check_output("reset_stop", stop, 0);
    check_output("reset_busy", busy, 0);
    #1;
    aresetn = 1'b1;
    checking = 1'b1;

    // Hand-computed anchors for the model's arithmetic.
    check_output("model_half_p0_f0", half_for(0, 3'b000), 5);
    check_output("model_half_p0_f1", half_for(0, 3'b001), 10);
    check_output("model_half_p2_clamp", half_for(2, 3'b100), 1);
    check_output("model_pix3_sel0", data_at(12, 3'b000), BG);
    check_output("model_pix3_sel1", data_at(12, 3'b001), FG);
    check_output("model_pix19_sel0", data_at(76, 3'b000), FG);

    repeat (2) @(negedge clock);
    #1;
    // Basic burst with retriggers in RUN and STOP and a 50-cycle held ack.
    apply_stimulus(3'b000, 1'b0, 1'b0, 50);
    repeat (3) @(negedge clock);
    #1;
    // Frequency select with done_ack tied high.
    apply_stimulus(3'b001, 1'b0, 1'b1, 0);
    repeat (2) @(negedge clock);
    #1;
    // Randomized bursts with input noise.
    for (int r = 0; r < 5; r++) begin
      apply_stimulus(3'($urandom_range(0, 7)), 1'b1, 1'b0, int'($urandom_range(0, 20)));
      repeat ($urandom_range(0, 4)) @(negedge clock);
      #1;
    end
    // Reset in the middle of RUN, then a clean restart.
    pulse_trigger(3'b110);
    repeat (49) @(negedge clock);
    #1;
    aresetn = 1'b0;
    #1;
    check_output("midrun_reset_data", data, BG);
    check_output("midrun_reset_pclk", pixel_clock, 0);
    check_output("midrun_reset_stop", stop, 0);
    check_output("midrun_reset_busy", busy, 0);
    @(negedge clock);
    #1;
    aresetn = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    apply_stimulus(3'b111, 1'b0, 1'b0, 3);
    repeat (3) @(negedge clock);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
